port_poller: RTL and testbench

//   Wishbone master that sits directly upstream of the GPIO port slave and drives it.

---
 rtl/port_poller.sv | 180 ++++++++++++++++++
 tb/tb_port_poller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_poller.sv
// port_poller: Wishbone master that configures a GPIO port as all-inputs, then
// reads its data register every PERIOD cycles. It keeps the last sample,
// accumulates sticky per-bit change flags and raises irq while any flag is set.
//
// Bus handshake: a transaction is open while wbCycO (and wbStbO, always equal)
// is high. The first clock edge that samples wbAckI=1 with the transaction
// open completes it, and the bus is dropped on that same edge, so an ack held
// for several cycles counts once. An ack seen while no transaction is open is
// ignored. A transaction that sees no ack for TIMEOUT cycles is abandoned.
module port_poller #(
    parameter int DATA_WIDTH = 16,
    parameter int PERIOD     = 1000,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  wbCycO,
    output logic                  wbStbO,
    output logic                  wbWeO,
    output logic                  wbAdrO,
    output logic [DATA_WIDTH-1:0] wbDatO,
    input  logic [DATA_WIDTH-1:0] wbDatI,
    input  logic                  wbAckI,
    input  logic [DATA_WIDTH-1:0] clrI,
    output logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] changed,
    output logic                  irq,
    output logic                  timeoutErr
);

    // Counter widths: the period counter holds PERIOD-1 down to 0, the
    // timeout counter counts cycles without ack up to TIMEOUT.
    localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] PERIOD_LOAD = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

    // Port register addresses on the single address line.
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_MODE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        WAIT = 2'd2,
        POLL = 2'd3
    } pollState_t;

    pollState_t      state;
    logic            cycReg;
    logic            weReg;
    logic            adrReg;
    logic            first;
    logic [PW-1:0]   periodCnt;
    logic [TW-1:0]   toCnt;

    logic                  pollAck;
    logic                  toExpire;
    logic [DATA_WIDTH-1:0] setMask;

    // Strobe mirrors cycle; write data is the all-inputs mode value, a
    // constant, so no register is needed to keep it glitch-free.
    assign wbCycO = cycReg;
    assign wbStbO = cycReg;
    assign wbWeO  = weReg;
    assign wbAdrO = adrReg;
    assign wbDatO = '0;

    // Interrupt is a pure OR of registered flags.
    assign irq = |changed;

    // Decode a completed read and the change bits it produces; the first read
    // after configuration only establishes the baseline.
    always_comb begin
        pollAck  = (state == POLL) && wbAckI;
        toExpire = (toCnt == TO_LAST);
        setMask  = '0;
        if (pollAck && !first) begin
            setMask = wbDatI ^ sample;
        end
    end

    // Main sequencer: configure, wait, poll; owns every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cycReg     <= 1'b0;
            weReg      <= 1'b0;
            adrReg     <= 1'b0;
            first      <= 1'b1;
            periodCnt  <= '0;
            toCnt      <= '0;
            sample     <= '0;
            changed    <= '0;
            timeoutErr <= 1'b0;
        end else begin
            // Clears apply in every state; a same-cycle set from a poll wins.
            changed <= (changed & ~clrI) | setMask;

            case (state)
                IDLE: begin
                    cycReg <= 1'b0;
                    weReg  <= 1'b0;
                    adrReg <= ADR_DATA;
                    if (enable) begin
                        state  <= CFG;
                        cycReg <= 1'b1;
                        weReg  <= 1'b1;
                        adrReg <= ADR_MODE;
                        toCnt  <= '0;
                        first  <= 1'b1;
                    end
                end

                CFG: begin
                    if (wbAckI) begin
                        cycReg    <= 1'b0;
                        weReg     <= 1'b0;
                        adrReg    <= ADR_DATA;
                        periodCnt <= PERIOD_LOAD;
                        state     <= WAIT;
                    end else if (toExpire) begin
                        // Abandon and fall back to IDLE, which retries the
                        // configuration write if enable is still high.
                        cycReg     <= 1'b0;
                        weReg      <= 1'b0;
                        adrReg     <= ADR_DATA;
                        timeoutErr <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (periodCnt == '0) begin
                        state  <= POLL;
                        cycReg <= 1'b1;
                        weReg  <= 1'b0;
                        adrReg <= ADR_DATA;
                        toCnt  <= '0;
                    end else begin
                        periodCnt <= periodCnt - 1'b1;
                    end
                end

                POLL: begin
                    if (pollAck) begin
                        sample    <= wbDatI;
                        first     <= 1'b0;
                        cycReg    <= 1'b0;
                        periodCnt <= PERIOD_LOAD;
                        state     <= WAIT;
                    end else if (toExpire) begin
                        // A lost read leaves sample and flags untouched and
                        // keeps the normal poll spacing.
                        cycReg     <= 1'b0;
                        timeoutErr <= 1'b1;
                        periodCnt  <= PERIOD_LOAD;
                        state      <= WAIT;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cycReg <= 1'b0;
                    weReg  <= 1'b0;
                    adrReg <= ADR_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_poller.sv
// tb_port_poller: directed bench for port_poller with a cycle-level reference
// model, a Wishbone slave model and hand-computed literal expectations.
module tb_port_poller;

    localparam int DW      = 16;
    localparam int PERIOD  = 8;
    localparam int TIMEOUT = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] clrI   = '0;
    logic          wbAckI = 1'b0;
    logic [DW-1:0] wbDatI = '0;

    logic          wbCycO, wbStbO, wbWeO, wbAdrO;
    logic [DW-1:0] wbDatO, sample, changed;
    logic          irq, timeoutErr;

    port_poller #(
        .DATA_WIDTH(DW),
        .PERIOD    (PERIOD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wbCycO    (wbCycO),
        .wbStbO    (wbStbO),
        .wbWeO     (wbWeO),
        .wbAdrO    (wbAdrO),
        .wbDatO    (wbDatO),
        .wbDatI    (wbDatI),
        .wbAckI    (wbAckI),
        .clrI      (clrI),
        .sample    (sample),
        .changed   (changed),
        .irq       (irq),
        .timeoutErr(timeoutErr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    // Acks an open transaction once it has been open more than ackDelay
    // cycles; read data comes from rdQ. ackHold keeps ack high (with
    // different data) for one cycle after the bus drops.
    logic [DW-1:0] rdQ[$];
    int  ackDelay = 1;
    bit  noAck    = 1'b0;
    bit  ackHold  = 1'b0;
    int  stbCnt   = 0;
    bit  inHold   = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            wbAckI = 1'b0;
            stbCnt = 0;
            inHold = 1'b0;
        end else if (wbStbO) begin
            stbCnt++;
            inHold = 1'b0;
            if (!noAck && stbCnt > ackDelay) begin
                wbAckI = 1'b1;
                if (!wbWeO && rdQ.size() > 0) wbDatI = rdQ.pop_front();
            end else begin
                wbAckI = 1'b0;
            end
        end else begin
            stbCnt = 0;
            if (wbAckI && ackHold && !inHold) begin
                inHold = 1'b1;
                wbDatI = ~wbDatI;
            end else begin
                wbAckI = 1'b0;
                inHold = 1'b0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction-level view: mKind is the transaction expected on the bus
    // this cycle (0 none, 1 mode write, 2 data read); nextPoll is the absolute
    // cycle at which the next read strobe must appear (-1 when not scheduled).
    int            cycN     = 0;
    int            mKind    = 0;
    int            mAge     = 0;
    int            nextPoll = -1;
    logic          mFirst   = 1'b1;
    logic          mTo      = 1'b0;
    logic [DW-1:0] mSample  = '0;
    logic [DW-1:0] mChanged = '0;
    logic [DW-1:0] mSet;

    always @(negedge clk) begin
        cycN++;
        if (rst) begin
            mKind = 0; mAge = 0; nextPoll = -1; mFirst = 1'b1;
            mTo = 1'b0; mSample = '0; mChanged = '0;
        end
        cmp("bus_cyc",  DW'(wbCycO), DW'(mKind != 0));
        cmp("bus_stb",  DW'(wbStbO), DW'(mKind != 0));
        cmp("bus_we",   DW'(wbWeO),  DW'(mKind == 1));
        cmp("bus_adr",  DW'(wbAdrO), DW'(mKind == 1));
        cmp("bus_dat",  wbDatO, '0);
        cmp("sample",   sample, mSample);
        cmp("changed",  changed, mChanged);
        cmp("irq",      DW'(irq), DW'(|mChanged));
        cmp("timeout",  DW'(timeoutErr), DW'(mTo));
        if (!rst) begin
            mSet = '0;
            if (mKind != 0) begin
                if (wbAckI) begin
                    if (mKind == 2) begin
                        if (!mFirst) mSet = wbDatI ^ mSample;
                        mSample = wbDatI;
                        mFirst  = 1'b0;
                    end
                    nextPoll = cycN + PERIOD + 1;
                    mKind    = 0;
                end else if (mAge + 1 == TIMEOUT) begin
                    mTo      = 1'b1;
                    nextPoll = (mKind == 2) ? cycN + PERIOD + 1 : -1;
                    mKind    = 0;
                end else begin
                    mAge++;
                end
            end else if (nextPoll >= 0) begin
                if (!enable) begin
                    nextPoll = -1;
                end else if (nextPoll == cycN + 1) begin
                    mKind = 2; mAge = 0; nextPoll = -1;
                end
            end else if (enable) begin
                mKind = 1; mAge = 0; mFirst = 1'b1;
            end
            mChanged = (mChanged & ~clrI) | mSet;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitStb(input logic lvl, input string nm);
        int k = 0;
        while (wbStbO !== lvl && k < 60) begin
            tick();
            k++;
        end
        cmp(nm, DW'(wbStbO), DW'(lvl));
    endtask

    task automatic countWhile(input logic lvl, output int n);
        n = 0;
        while (wbStbO === lvl && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic doRead();
        waitStb(1'b1, "rd_start");
        waitStb(1'b0, "rd_end");
    endtask

    task automatic countStrobes(input int cycles, output int s);
        s = 0;
        repeat (cycles) begin
            tick();
            if (wbStbO) s++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int k;

        repeat (3) tick();
        cmp("rst_cyc",     DW'(wbCycO), '0);
        cmp("rst_sample",  sample, '0);
        cmp("rst_changed", changed, '0);
        rst = 1'b0;
        tick(); tick();
        cmp("idle_no_bus", DW'(wbCycO), '0);

        // Configure then three reads: baseline, no change, bits 0 and 8 change.
        rdQ.push_back(16'h00F0);
        rdQ.push_back(16'h00F0);
        rdQ.push_back(16'h01F1);
        enable = 1'b1;
        waitStb(1'b1, "cfg_start");
        cmp("cfg_we",  DW'(wbWeO),  DW'(1'b1));
        cmp("cfg_adr", DW'(wbAdrO), DW'(1'b1));
        cmp("cfg_dat", wbDatO, '0);
        waitStb(1'b0, "cfg_end");
        countWhile(1'b0, n);
        cmp("gap_after_cfg", DW'(n), DW'(PERIOD));
        cmp("rd_we",  DW'(wbWeO),  '0);
        cmp("rd_adr", DW'(wbAdrO), '0);
        waitStb(1'b0, "rd1_end");
        tick();
        cmp("baseline_sample",  sample, 16'h00F0);
        cmp("baseline_changed", changed, '0);
        doRead();
        countWhile(1'b0, n);
        cmp("gap_after_read", DW'(n), DW'(PERIOD));
        waitStb(1'b0, "rd3_end");
        tick(); tick();
        cmp("t3_sample",  sample, 16'h01F1);
        cmp("t3_changed", changed, 16'h0101);
        cmp("t3_irq",     DW'(irq), DW'(1'b1));

        // Clear bit 0 in the same cycle a poll sees bit 0 toggle: set wins.
        rdQ.push_back(16'h01F0);
        k = 0;
        while (wbAckI !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        cmp("t4_ack_seen", DW'(wbAckI), DW'(1'b1));
        clrI = 16'h0001;
        tick();
        clrI = '0;
        cmp("t4_set_wins", changed, 16'h0101);
        tick();
        clrI = 16'h0101;
        tick();
        clrI = '0;
        cmp("t4_cleared", changed, '0);
        cmp("t4_irq_low", DW'(irq), '0);
        rdQ.push_back(16'h01F0);
        doRead();
        tick();
        cmp("t4_no_toggle", changed, '0);

        // Slower slave, wider change pattern.
        ackDelay = 3;
        rdQ.push_back(16'hFFFF);
        doRead();
        ackDelay = 1;
        tick();
        cmp("wide_changed", changed, 16'hFE0F);
        cmp("wide_sample",  sample, 16'hFFFF);

        // Ack held into the following cycle with different data is ignored.
        ackHold = 1'b1;
        rdQ.push_back(16'hFFFF);
        doRead();
        tick(); tick();
        ackHold = 1'b0;
        cmp("hold_sample",  sample, 16'hFFFF);
        cmp("hold_changed", changed, 16'hFE0F);

        // Read timeout: strobe held exactly TIMEOUT cycles, next poll on time.
        noAck = 1'b1;
        waitStb(1'b1, "t5_start");
        countWhile(1'b1, n);
        cmp("t5_stb_cycles", DW'(n), DW'(TIMEOUT));
        cmp("t5_err",        DW'(timeoutErr), DW'(1'b1));
        cmp("t5_sample",     sample, 16'hFFFF);
        noAck = 1'b0;
        countWhile(1'b0, n);
        cmp("t5_gap", DW'(n), DW'(PERIOD));
        rdQ.push_back(16'hFFFF);
        waitStb(1'b0, "t5_next_end");

        // Disable during WAIT: no further strobes.
        tick(); tick();
        enable = 1'b0;
        countStrobes(30, n);
        cmp("t6_wait_quiet", DW'(n), '0);

        // Re-enable: configuration restarts; disable while a read is open.
        enable = 1'b1;
        waitStb(1'b1, "t6_cfg");
        cmp("t6_cfg_we", DW'(wbWeO), DW'(1'b1));
        waitStb(1'b0, "t6_cfg_end");
        rdQ.push_back(16'h1234);
        waitStb(1'b1, "t6_rd");
        enable = 1'b0;
        waitStb(1'b0, "t6_rd_end");
        tick();
        cmp("t6_sample",  sample, 16'h1234);
        cmp("t6_changed", changed, 16'hFE0F);
        countStrobes(30, n);
        cmp("t6_poll_quiet", DW'(n), '0);

        // Asynchronous reset in the middle of an open read.
        enable = 1'b1;
        waitStb(1'b1, "t1_cfg");
        waitStb(1'b0, "t1_cfg_end");
        noAck = 1'b1;
        waitStb(1'b1, "t1_rd");
        #1;
        rst = 1'b1;
        #1;
        cmp("t1_cyc",     DW'(wbCycO), '0);
        cmp("t1_stb",     DW'(wbStbO), '0);
        cmp("t1_we",      DW'(wbWeO), '0);
        cmp("t1_sample",  sample, '0);
        cmp("t1_changed", changed, '0);
        cmp("t1_irq",     DW'(irq), '0);
        cmp("t1_err",     DW'(timeoutErr), '0);
        noAck = 1'b0;
        tick(); tick();
        rst = 1'b0;
        waitStb(1'b1, "t1_restart");
        cmp("t1_restart_we",  DW'(wbWeO), DW'(1'b1));
        cmp("t1_restart_adr", DW'(wbAdrO), DW'(1'b1));
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
